// File: rtl/stream_demux_4b_1to5.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_4b_1to5
// Purpose  : Registered 1-to-5 val/rdy stream demultiplexer. Each accepted
//            message is steered by in_sel into one of five single-entry lane
//            registers, and each register is drained by its own consumer.
//            Selects 5..7 have no destination. Those messages are accepted
//            and discarded.
// Ports    : clk, reset_n (async active-low)
//            in_val/in_rdy/in_msg/in_sel     - producer side
//            out_val[4:0]/out_rdy[4:0]       - per-lane handshake
//            out_msg[5*NBITS-1:0]            - lane i at [NBITS*i +: NBITS]
//            drop_count[7:0]                 - saturating drop counter
// Options  : STREAM_DEMUX_DROP_CNT_EN - when defined, drop_count counts
//            dropped messages and saturates at 255. When undefined,
//            drop_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_4b_1to5 #(
    parameter int NBITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [NBITS-1:0]     in_msg,
    input  logic [2:0]           in_sel,
    output logic [4:0]           out_val,
    input  logic [4:0]           out_rdy,
    output logic [5*NBITS-1:0]   out_msg,
    output logic [7:0]           drop_count
);

    localparam logic [2:0] c_NUM_LANES = 3'd5;

    logic [4:0]       full_q, full_d;
    logic [NBITS-1:0] data_q [5];
    logic [NBITS-1:0] data_d [5];

    logic w_sel_lane;   // in_sel addresses a real lane
    logic w_lane_rdy;   // addressed lane can take a message this cycle
    logic w_in_xfer;

    // in_rdy depends only on in_sel, lane state and out_rdy, never on in_val.
    // A full lane whose consumer is draining this cycle can accept again,
    // which keeps back-to-back traffic into one lane bubble-free.
    always_comb begin
        w_sel_lane = (in_sel < c_NUM_LANES);
        w_lane_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (in_sel == 3'(i)) begin
                w_lane_rdy = ~full_q[i] | out_rdy[i];
            end
        end
        in_rdy    = w_sel_lane ? w_lane_rdy : 1'b1;
        w_in_xfer = in_val & in_rdy;
    end

    // Per-lane next state. A write to a lane overrides a drain in the same
    // cycle. Data is left stale on drain.
    always_comb begin
        full_d = full_q;
        for (int i = 0; i < 5; i++) begin
            data_d[i] = data_q[i];
            if (full_q[i] && out_rdy[i]) begin
                full_d[i] = 1'b0;
            end
            if (w_in_xfer && (in_sel == 3'(i))) begin
                full_d[i] = 1'b1;
                data_d[i] = in_msg;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= '0;
            for (int i = 0; i < 5; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int i = 0; i < 5; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_val = full_q;

    generate
        for (genvar g = 0; g < 5; g++) begin : g_lane
            assign out_msg[NBITS*g +: NBITS] = data_q[g];
        end
    endgenerate

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (w_in_xfer && !w_sel_lane && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_q <= 8'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule
`default_nettype wire
